// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, mid-bit sampling at a per-frame divider,
// optional parity and second stop bit, one-cycle valid strobe with error flags.
module uart_rx #(
  parameter int CLOCK_DIVIDER_WIDTH = 8
) (
  input  logic                           clock_i,
  input  logic                           reset_i,
  input  logic                           serial_i,
  input  logic                           two_stop_bits_i,
  input  logic                           parity_bit_i,
  input  logic                           parity_even_i,
  input  logic [CLOCK_DIVIDER_WIDTH-1:0] clock_divider_i,
  output logic [7:0]                     data_o,
  output logic                           valid_o,
  output logic                           parity_error_o,
  output logic                           frame_error_o,
  output logic                           busy_o
);

  localparam int W = CLOCK_DIVIDER_WIDTH;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, DONE} state_t;

  state_t         state_reg, state_next;
  logic           sync1_reg, rx_s_reg, rx_prev_reg;
  logic [W-1:0]   cnt_reg, cnt_next;
  logic [W-1:0]   cfg_div_reg, cfg_div_next;
  logic           cfg_parity_reg, cfg_parity_next;
  logic           cfg_even_reg, cfg_even_next;
  logic           cfg_two_stop_reg, cfg_two_stop_next;
  logic [7:0]     shift_reg, shift_next;
  logic [2:0]     bit_idx_reg, bit_idx_next;
  logic           par_err_reg, par_err_next;
  logic           frm_err_reg, frm_err_next;
  logic [7:0]     data_reg, data_next;
  logic           perr_out_reg, perr_out_next;
  logic           ferr_out_reg, ferr_out_next;

  logic [W-1:0]   div_eff;
  logic           bit_tick;
  logic           stop_err;

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      sync1_reg        <= 1'b1;
      rx_s_reg         <= 1'b1;
      rx_prev_reg      <= 1'b1;
      state_reg        <= IDLE;
      cnt_reg          <= '0;
      cfg_div_reg      <= W'(2);
      cfg_parity_reg   <= 1'b0;
      cfg_even_reg     <= 1'b0;
      cfg_two_stop_reg <= 1'b0;
      shift_reg        <= '0;
      bit_idx_reg      <= '0;
      par_err_reg      <= 1'b0;
      frm_err_reg      <= 1'b0;
      data_reg         <= '0;
      perr_out_reg     <= 1'b0;
      ferr_out_reg     <= 1'b0;
    end else begin
      sync1_reg        <= serial_i;
      rx_s_reg         <= sync1_reg;
      rx_prev_reg      <= rx_s_reg;
      state_reg        <= state_next;
      cnt_reg          <= cnt_next;
      cfg_div_reg      <= cfg_div_next;
      cfg_parity_reg   <= cfg_parity_next;
      cfg_even_reg     <= cfg_even_next;
      cfg_two_stop_reg <= cfg_two_stop_next;
      shift_reg        <= shift_next;
      bit_idx_reg      <= bit_idx_next;
      par_err_reg      <= par_err_next;
      frm_err_reg      <= frm_err_next;
      data_reg         <= data_next;
      perr_out_reg     <= perr_out_next;
      ferr_out_reg     <= ferr_out_next;
    end
  end

  // Dividers below 2 would leave no room for a mid-bit sample.
  assign div_eff  = (clock_divider_i < W'(2)) ? W'(2) : clock_divider_i;
  // cnt is 1 in the first cycle after the reference point, so it equals the
  // elapsed cycle count: H for the start-bit midpoint, D between later samples.
  assign bit_tick = (state_reg == START) ? (cnt_reg == (cfg_div_reg >> 1)) : (cnt_reg == cfg_div_reg);
  assign stop_err = frm_err_reg | ~rx_s_reg;

  always_comb begin
    state_next        = state_reg;
    cnt_next          = cnt_reg + W'(1);
    cfg_div_next      = cfg_div_reg;
    cfg_parity_next   = cfg_parity_reg;
    cfg_even_next     = cfg_even_reg;
    cfg_two_stop_next = cfg_two_stop_reg;
    shift_next        = shift_reg;
    bit_idx_next      = bit_idx_reg;
    par_err_next      = par_err_reg;
    frm_err_next      = frm_err_reg;
    data_next         = data_reg;
    perr_out_next     = perr_out_reg;
    ferr_out_next     = ferr_out_reg;
    if (bit_tick) cnt_next = W'(1);

    case (state_reg)
      IDLE: begin
        cnt_next = W'(1);
        if (rx_prev_reg && !rx_s_reg) begin
          state_next        = START;
          cfg_div_next      = div_eff;
          cfg_parity_next   = parity_bit_i;
          cfg_even_next     = parity_even_i;
          cfg_two_stop_next = two_stop_bits_i;
          bit_idx_next      = '0;
          par_err_next      = 1'b0;
          frm_err_next      = 1'b0;
        end
      end
      START: begin
        if (bit_tick) state_next = rx_s_reg ? IDLE : DATA;
      end
      DATA: begin
        if (bit_tick) begin
          shift_next   = {rx_s_reg, shift_reg[7:1]};
          bit_idx_next = bit_idx_reg + 3'd1;
          if (bit_idx_reg == 3'd7) state_next = cfg_parity_reg ? PARITY : STOP1;
        end
      end
      PARITY: begin
        if (bit_tick) begin
          par_err_next = (^shift_reg) ^ rx_s_reg ^ ~cfg_even_reg;
          state_next   = STOP1;
        end
      end
      STOP1, STOP2: begin
        if (bit_tick) begin
          frm_err_next = stop_err;
          if (state_reg == STOP1 && cfg_two_stop_reg) begin
            state_next = STOP2;
          end else begin
            state_next    = DONE;
            data_next     = shift_reg;
            perr_out_next = par_err_reg;
            ferr_out_next = stop_err;
          end
        end
      end
      DONE: begin
        cnt_next   = W'(1);
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign data_o         = data_reg;
  assign parity_error_o = perr_out_reg;
  assign frame_error_o  = ferr_out_reg;
  assign valid_o        = (state_reg == DONE);
  assign busy_o         = (state_reg != IDLE) && (state_reg != DONE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are driven bit by bit and every valid
// pulse is logged with its cycle, then compared to hand-computed results.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       serial = 1'b1;
  logic       two_stop = 1'b0;
  logic       par_en = 1'b0;
  logic       par_even = 1'b0;
  logic [7:0] div = 8'd4;
  logic [7:0] data_o;
  logic       valid_o, parity_error_o, frame_error_o, busy_o;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  int n_pulses = 0;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    int         at;
  } ev_t;
  ev_t evq[$];

  uart_rx #(.CLOCK_DIVIDER_WIDTH(8)) dut (
    .clock_i         (clk),
    .reset_i         (rst_n),
    .serial_i        (serial),
    .two_stop_bits_i (two_stop),
    .parity_bit_i    (par_en),
    .parity_even_i   (par_even),
    .clock_divider_i (div),
    .data_o          (data_o),
    .valid_o         (valid_o),
    .parity_error_o  (parity_error_o),
    .frame_error_o   (frame_error_o),
    .busy_o          (busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (valid_o) begin
      ev_t e;
      e.data = data_o;
      e.perr = parity_error_o;
      e.ferr = frame_error_o;
      e.at   = cyc;
      evq.push_back(e);
      n_pulses++;
      $display("valid at cycle %0d: data=0x%02h perr=%0b ferr=%0b", cyc, data_o, parity_error_o, frame_error_o);
      check("busy_low_in_done", {31'd0, busy_o}, 32'd0);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives start, 8 data bits LSB first, optional parity, then 1 or 2 stop bits.
  task automatic send_frame(input logic [7:0] d, input bit with_par, input logic par_val,
                            input int nstop, input logic stop2_val, input int bit_len,
                            output int start);
    logic [11:0] bits;
    int nb;
    bit busy_ok;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    nb = 9;
    if (with_par) begin
      bits[9] = par_val;
      nb = 10;
    end
    bits[nb] = 1'b1;
    nb = nb + 1;
    if (nstop == 2) begin
      bits[nb] = stop2_val;
      nb = nb + 1;
    end
    busy_ok = 1'b1;
    start = 0;
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < bit_len; c++) begin
        @(posedge clk);
        #1;
        if (b == 0 && c == 0) start = cyc;
        serial = bits[b];
        if (b * bit_len + c >= 3) busy_ok = busy_ok & busy_o;
      end
    end
    if (bits[nb-1] == 1'b0) begin
      @(posedge clk);
      #1;
      serial = 1'b1;
    end
    check("busy_during_frame", {31'd0, busy_ok}, 32'd1);
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] d, input logic pe,
                              input logic fe, input int at);
    ev_t e;
    if (evq.size() == 0) begin
      check({tag, "_present"}, 32'd0, 32'd1);
    end else begin
      e = evq.pop_front();
      check({tag, "_data"}, {24'd0, e.data}, {24'd0, d});
      check({tag, "_perr"}, {31'd0, e.perr}, {31'd0, pe});
      check({tag, "_ferr"}, {31'd0, e.ferr}, {31'd0, fe});
      check({tag, "_cycle"}, e.at, at);
    end
  endtask

  initial begin
    int s1, s2;
    rst_n = 1'b0;
    tick(3);
    check("rst_data", {24'd0, data_o}, 32'd0);
    check("rst_valid", {31'd0, valid_o}, 32'd0);
    check("rst_perr", {31'd0, parity_error_o}, 32'd0);
    check("rst_ferr", {31'd0, frame_error_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    rst_n = 1'b1;
    tick(5);

    // D=4, 8N1, back-to-back; valid at start + 2 + H + 9D + 1 = start + 41
    div = 8'd4;
    send_frame(8'h55, 0, 1'b0, 1, 1'b1, 4, s1);
    send_frame(8'hAA, 0, 1'b0, 1, 1'b1, 4, s2);
    tick(30);
    check("b2b_count", evq.size(), 32'd2);
    expect_frame("b2b0", 8'h55, 1'b0, 1'b0, s1 + 41);
    expect_frame("b2b1", 8'hAA, 1'b0, 1'b0, s2 + 41);

    // Parity adds D: valid at start + 45
    par_en = 1'b1;
    par_even = 1'b1;
    send_frame(8'hA5, 1, 1'b0, 1, 1'b1, 4, s1);
    tick(20);
    expect_frame("even_ok", 8'hA5, 1'b0, 1'b0, s1 + 45);
    send_frame(8'hA5, 1, 1'b1, 1, 1'b1, 4, s1);
    tick(20);
    expect_frame("even_bad", 8'hA5, 1'b1, 1'b0, s1 + 45);
    par_even = 1'b0;
    send_frame(8'hA5, 1, 1'b1, 1, 1'b1, 4, s1);
    tick(20);
    expect_frame("odd_ok", 8'hA5, 1'b0, 1'b0, s1 + 45);

    // Two stop bits, second one low: c0 + 43 where c0 = start + 2
    par_en = 1'b0;
    two_stop = 1'b1;
    send_frame(8'h3C, 0, 1'b0, 2, 1'b0, 4, s1);
    tick(20);
    expect_frame("stop2_low", 8'h3C, 1'b0, 1'b1, s1 + 45);
    two_stop = 1'b0;

    // D=8 glitch: false start, busy gone by c0 + 5
    div = 8'd8;
    tick(2);
    serial = 1'b0;
    s1 = cyc;
    tick(2);
    serial = 1'b1;
    tick(1);
    check("glitch_busy_rise", {31'd0, busy_o}, 32'd1);
    tick(4);
    check("glitch_busy_fall", {31'd0, busy_o}, 32'd0);
    tick(30);
    check("glitch_no_valid", evq.size(), 32'd0);
    check("glitch_data_hold", {24'd0, data_o}, 32'h3C);
    check("glitch_ferr_hold", {31'd0, frame_error_o}, 32'd1);

    // Reset during data bit 3 of 0xFF, then a clean 0x81
    div = 8'd4;
    tick(2);
    serial = 1'b0;
    tick(4);
    serial = 1'b1;
    tick(15);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy_o}, 32'd0);
    check("abort_data", {24'd0, data_o}, 32'd0);
    check("abort_ferr", {31'd0, frame_error_o}, 32'd0);
    tick(3);
    rst_n = 1'b1;
    tick(60);
    check("abort_no_valid", evq.size(), 32'd0);
    send_frame(8'h81, 0, 1'b0, 1, 1'b1, 4, s1);
    tick(20);
    expect_frame("after_abort", 8'h81, 1'b0, 1'b0, s1 + 41);

    // Divider 0 behaves as 2: valid at start + 2 + 1 + 18 + 1
    div = 8'd0;
    send_frame(8'h0F, 0, 1'b0, 1, 1'b1, 2, s1);
    tick(20);
    expect_frame("div0", 8'h0F, 1'b0, 1'b0, s1 + 22);

    check("total_pulses", n_pulses, 32'd8);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Asynchronous serial receiver; the receive-side counterpart of the UartTx transmitter, configured through the same per-frame controls (divider, parity, stop bits).
- Oversamples `serial_i` at `clock_divider_i` clocks per bit and samples each bit at its midpoint.
- Delivers an 8-bit byte with a one-cycle valid strobe plus parity and framing error flags to the host logic beside the transmitter.

Parameters:
- CLOCK_DIVIDER_WIDTH, 8, width of `clock_divider_i` and of the internal bit-timing counter.

Ports:
- clock_i  input  1  system clock; all logic on rising edge.
- reset_i  input  1  asynchronous, active-low reset.
- serial_i  input  1  UART line, idle high; asynchronous to clock_i.
- two_stop_bits_i  input  1  1 = expect 2 stop bits.
- parity_bit_i  input  1  1 = a parity bit follows data bit 7.
- parity_even_i  input  1  1 = even parity, 0 = odd.
- clock_divider_i  input  CLOCK_DIVIDER_WIDTH  clocks per bit (D).
- data_o  output  8  last received byte, LSB received first.
- valid_o  output  1  one-cycle strobe: data_o and the error flags are updated.
- parity_error_o  output  1  parity mismatch on the last frame.
- frame_error_o  output  1  a stop bit sampled low on the last frame.
- busy_o  output  1  frame reception in progress.

Behaviour:
- Reset (reset_i low, asynchronous): all outputs 0; FSM in IDLE; both synchronizer flops set to 1 (line idle).
- Input path: 2-flop synchronizer on `serial_i`. Edge detection and all sampling use the second flop (`rx_s`).
- Divider rule: D = max(clock_divider_i, 2), so values 0 and 1 behave as 2. H = floor(D/2).
- Configuration latch: D, parity_bit_i, parity_even_i and two_stop_bits_i are captured at start detection and held for the whole frame. Mid-frame input changes are ignored.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, DONE.
- IDLE: wait for `rx_s` 1->0; the cycle that edge is seen is c0. busy_o rises in cycle c0+1. Go to START.
- START: sample at c0+H.
  - Sample high: false start. Return to IDLE, busy_o drops, no valid_o, outputs unchanged.
  - Sample low: go to DATA.
- DATA: bit n (n = 0..7) sampled at c0+H+D*(n+1) into a shift register, LSB first. After bit 7, go to PARITY if parity is enabled, else STOP1.
- PARITY: sampled at c0+H+9D.
  - Error when the XOR of the 8 data bits plus the parity bit is 1 for even parity, or 0 for odd parity.
- STOP1: sampled one D after the last data/parity sample. Low sets the frame error. Go to STOP2 if two stop bits are enabled, else DONE.
- STOP2: sampled D later. Low also sets the frame error.
- DONE (one cycle), the cycle after the final stop sample:
  - valid_o = 1.
  - data_o, parity_error_o and frame_error_o are loaded with the frame results. parity_error_o is 0 when parity is disabled.
  - busy_o = 0 in this cycle.
  - Return to IDLE.
- Latency, no parity, 1 stop bit: valid_o in cycle c0+H+9D+1 (D=4: c0+39). Each enabled parity bit or extra stop bit adds D.
- Hold: data_o and the error flags stay stable until the next DONE. A frame with errors still asserts valid_o and updates data_o.
- No flow control: a new frame overwrites data_o regardless of consumption.
- Back-to-back frames: IDLE re-arms in the DONE cycle. A start edge arriving ≥1 cycle after DONE is received without loss.
- Low-after-stop: if the line is still low after a frame (break or a stop-bit error), the receiver does not restart. It requires a 1 seen in IDLE before the next falling edge.
- Reset mid-frame: immediate abort to IDLE, all outputs cleared, no valid_o.

Test Plan:
- D=4, 8N1, send 0x55 then 0xAA back-to-back (one stop bit each) -> exactly two valid_o pulses, data_o = 0x55 then 0xAA, both error flags 0, busy_o high throughout each frame and low in each DONE cycle.
- D=4, parity even, send 0xA5 with parity bit 0 -> data_o = 0xA5, parity_error_o = 0. Repeat with parity bit 1 -> parity_error_o = 1, valid_o still pulses. Repeat odd parity with parity bit 1 -> parity_error_o = 0.
- D=4, 2 stop bits, send 0x3C with the second stop bit driven low -> data_o = 0x3C, frame_error_o = 1, valid_o pulses at c0+2+9*4+4+1 = c0+43.
- D=8, drive a 2-cycle low glitch on serial_i while idle -> no valid_o, busy_o returns low by c0+5, data_o unchanged.
- D=4, assert reset_i low during data bit 3 of 0xFF, release, then send 0x81 -> no pulse for the aborted frame, next valid_o with data_o = 0x81.
- clock_divider_i = 0, send 0x0F at 2 clocks/bit -> data_o = 0x0F, no errors.
